rbm_vote_decoder: RTL and testbench
===================================

// Module: rbm_vote_decoder
// PURPOSE
//  Consumer side of the RBM top-level result interface. Waits for finish, then latches the
//  per-class vote counters in OutputData. Scans them sequentially (one class per clock) to
//  find the winning class and presents it on a valid/ready handshake to the host/test logic.
//  Sits directly downstream of the RBM top and re-arms only after finish deasserts.
// PARAMETERS
//  output_dim      10  number of classes (vote counters)
//  w_bitlength     12  width of each vote counter in OutputData
//  label_bitlength 4   width of label output; must be >= clog2(output_dim)
//  min_margin      2   margin threshold for low_conf (used only with MARGIN_CHECK_EN)
// PORTS
//  clock        in   1                        rising-edge clock
//  reset_n      in   1                        asynchronous, active-low reset
//  finish       in   1                        RBM top done; level, held high until RBM reset
//  OutputData   in   `PORT_1D(output_dim,w_bitlength)  vote counters; valid while finish=1
//  label_valid  out  1                        result available
//  label_ready  in   1                        consumer accepts result
//  label        out  label_bitlength          winning class index
//  label_votes  out  w_bitlength              vote count of winning class
//  no_vote      out  1                        all counters were zero (label=0)
//  margin       out  w_bitlength              best minus second-best (MARGIN_CHECK_EN only)
//  low_conf     out  1                        margin < min_margin (MARGIN_CHECK_EN only)
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE; every output 0; vote regs, idx, best regs 0.
//  - IDLE: on first edge sampling finish=1 with finish_q=0 (rising edge), latch all OutputData
//    into vote regs; set idx=0, best=0, best_idx=0, second=0; go to SCAN. finish already high
//    out of reset counts as a rising edge (finish_q resets to 0).
//  - SCAN: one class per edge. If vote[idx] > best: second<=best, best<=vote, best_idx<=idx.
//    Else if vote[idx] > second: second<=vote. Strict > means ties resolve to the lowest index.
//    After idx=output_dim-1, go to HOLD. Otherwise idx<=idx+1. The scan takes output_dim edges.
//  - Latency: label_valid rises output_dim+1 edges after the edge that latched the data.
//  - HOLD: label_valid=1. label, label_votes, no_vote and margin are stable. On an edge with
//    label_ready=1, clear label_valid; go to WAIT_CLR. Data outputs keep their values until the
//    next latch.
//  - WAIT_CLR: wait for finish=0, then go to IDLE. This prevents double decode of a held finish.
//  - finish falling during SCAN/HOLD: ignored (data already latched); the FSM skips the
//    WAIT_CLR wait once finish is seen low.
//  - label_ready while not in HOLD: ignored.
//  - no_vote=1 iff best==0 at end of scan.
//  - Comparisons are unsigned w_bitlength. No arithmetic widening is needed.
//  - Reset mid-SCAN/HOLD: the result is discarded; no label_valid pulse.
// CONFIGURATION
//  MARGIN_CHECK_EN defined:
//   - second-best tracking is built.
//   - margin=best-second, registered on entry to HOLD.
//   - low_conf=(margin<min_margin).
//  MARGIN_CHECK_EN undefined:
//   - second-best logic is removed.
//   - margin and low_conf are tied to 0; the ports remain for a fixed interface.
// STRUCTURE
//  - Shared header rbm_defs.vh (alongside config.v) holds:
//    - FSM state localparams IDLE/SCAN/HOLD/WAIT_CLR (2-bit);
//    - the PORT_1D/GET_1D macros.
//  - One sub-module: rbm_vote_compare (combinational).
//    - Inputs: candidate, idx, best, best_idx, second.
//    - Outputs: next best/best_idx/second.
//  - The top holds the FSM, vote regs, idx counter and output regs.
// TESTING
//  1. votes={c3=20, others 1}, finish 0->1 -> label_valid after 11 edges, label=3,
//     label_votes=20, no_vote=0.
//  2. Tie: c2=15, c7=15, rest 0 -> label=2. With MARGIN_CHECK_EN: margin=0, low_conf=1.
//  3. All votes 0 -> label=0, no_vote=1, label_votes=0.
//  4. label_ready held 0 for 5 cycles -> label_valid and label stable.
//     Then ready=1 -> valid drops next edge.
//     finish kept high -> no second decode until finish 0 then 1 again.
//  5. reset_n pulled low mid-SCAN (idx=4) -> all outputs 0 immediately.
//     After release and a new finish edge -> correct fresh result.
//  6. Max count: c9=4095 (w_bitlength=12), c0=4094 -> label=9.
//     With MARGIN_CHECK_EN: margin=1, low_conf=1.

Source files
------------

// File: rtl/rbm_vote_decoder_pkg.sv
// rbm_vote_decoder_pkg: shared defaults and FSM state type for the RBM vote decoder.
package rbm_vote_decoder_pkg;
    localparam int OUTPUT_DIM      = 10;
    localparam int W_BITLENGTH     = 12;
    localparam int LABEL_BITLENGTH = 4;
    localparam int MIN_MARGIN      = 2;
    typedef enum logic [1:0] {IDLE, SCAN, HOLD, WAIT_CLR} state_e;
endpackage

// File: rtl/rbm_vote_decoder_compare.sv
// rbm_vote_decoder_compare: one scan step of the winner search (strict >, so ties keep the lowest index).
// Second-best tracking exists only when MARGIN_CHECK_EN is defined.
module rbm_vote_decoder_compare #(
    parameter int w_bitlength     = 12,
    parameter int label_bitlength = 4
) (
    input  logic [w_bitlength-1:0]     candidate_i,
    input  logic [label_bitlength-1:0] idx_i,
    input  logic [w_bitlength-1:0]     best_i,
    input  logic [label_bitlength-1:0] best_idx_i,
    input  logic [w_bitlength-1:0]     second_i,
    output logic [w_bitlength-1:0]     best_o,
    output logic [label_bitlength-1:0] best_idx_o,
    output logic [w_bitlength-1:0]     second_o
);
    logic gt_best;
    assign gt_best    = candidate_i > best_i;
    assign best_o     = gt_best ? candidate_i : best_i;
    assign best_idx_o = gt_best ? idx_i : best_idx_i;
`ifdef MARGIN_CHECK_EN
    assign second_o   = gt_best ? best_i : (candidate_i > second_i ? candidate_i : second_i);
`else
    assign second_o   = second_i;
`endif
endmodule

// File: rtl/rbm_vote_decoder.sv
// rbm_vote_decoder: latches RBM vote counters on finish, scans one class per clock for the winner,
// and offers it on a valid/ready handshake. Optional MARGIN_CHECK_EN adds margin/low_conf.
module rbm_vote_decoder
    import rbm_vote_decoder_pkg::*;
#(
    parameter int output_dim      = OUTPUT_DIM,
    parameter int w_bitlength     = W_BITLENGTH,
    parameter int label_bitlength = LABEL_BITLENGTH,
    parameter int min_margin      = MIN_MARGIN
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              finish,
    input  logic [output_dim*w_bitlength-1:0] OutputData,
    output logic                              label_valid,
    input  logic                              label_ready,
    output logic [label_bitlength-1:0]        label,
    output logic [w_bitlength-1:0]            label_votes,
    output logic                              no_vote,
    output logic [w_bitlength-1:0]            margin,
    output logic                              low_conf
);
    localparam logic [label_bitlength-1:0] LAST = label_bitlength'(output_dim - 1);

    state_e                       state_q, state_d;
    logic                         finish_q;
    logic [w_bitlength-1:0]       vote_q [output_dim];
    logic [w_bitlength-1:0]       vote_d [output_dim];
    logic [label_bitlength-1:0]   idx_q, idx_d, best_idx_q, best_idx_d, label_q, label_d;
    logic [w_bitlength-1:0]       best_q, best_d, second_q, second_d;
    logic [w_bitlength-1:0]       votes_q, votes_d, margin_q, margin_d;
    logic                         valid_q, valid_d, no_vote_q, no_vote_d, low_conf_q, low_conf_d;
    logic [w_bitlength-1:0]       cmp_best, cmp_second;
    logic [label_bitlength-1:0]   cmp_best_idx;

    rbm_vote_decoder_compare #(
        .w_bitlength    (w_bitlength),
        .label_bitlength(label_bitlength)
    ) u_compare (
        .candidate_i(vote_q[idx_q]),
        .idx_i      (idx_q),
        .best_i     (best_q),
        .best_idx_i (best_idx_q),
        .second_i   (second_q),
        .best_o     (cmp_best),
        .best_idx_o (cmp_best_idx),
        .second_o   (cmp_second)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            finish_q   <= 1'b0;
            for (int i = 0; i < output_dim; i++) vote_q[i] <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            second_q   <= '0;
            valid_q    <= 1'b0;
            label_q    <= '0;
            votes_q    <= '0;
            no_vote_q  <= 1'b0;
            margin_q   <= '0;
            low_conf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            finish_q   <= finish;
            vote_q     <= vote_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            second_q   <= second_d;
            valid_q    <= valid_d;
            label_q    <= label_d;
            votes_q    <= votes_d;
            no_vote_q  <= no_vote_d;
            margin_q   <= margin_d;
            low_conf_q <= low_conf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vote_d     = vote_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        second_d   = second_q;
        valid_d    = valid_q;
        label_d    = label_q;
        votes_d    = votes_q;
        no_vote_d  = no_vote_q;
        margin_d   = margin_q;
        low_conf_d = low_conf_q;
        case (state_q)
            IDLE: if (finish && !finish_q) begin
                for (int i = 0; i < output_dim; i++) vote_d[i] = OutputData[i*w_bitlength +: w_bitlength];
                idx_d      = '0;
                best_d     = '0;
                best_idx_d = '0;
                second_d   = '0;
                state_d    = SCAN;
            end
            SCAN: begin
                best_d     = cmp_best;
                best_idx_d = cmp_best_idx;
                second_d   = cmp_second;
                idx_d      = idx_q + 1'b1;
                state_d    = (idx_q == LAST) ? HOLD : SCAN;
            end
            // First HOLD cycle publishes the result; later cycles wait for the consumer.
            HOLD: if (!valid_q) begin
                valid_d   = 1'b1;
                label_d   = best_idx_q;
                votes_d   = best_q;
                no_vote_d = (best_q == '0);
`ifdef MARGIN_CHECK_EN
                margin_d   = best_q - second_q;
                low_conf_d = (best_q - second_q) < w_bitlength'(min_margin);
`endif
            end else if (label_ready) begin
                valid_d = 1'b0;
                state_d = finish ? WAIT_CLR : IDLE;
            end
            WAIT_CLR: state_d = finish ? WAIT_CLR : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign label_valid = valid_q;
    assign label       = label_q;
    assign label_votes = votes_q;
    assign no_vote     = no_vote_q;
    assign margin      = margin_q;
    assign low_conf    = low_conf_q;
endmodule

// File: tb/tb_rbm_vote_decoder.sv
// tb_rbm_vote_decoder: directed and randomized decode runs checked against an argmax/second-max model.
module tb_rbm_vote_decoder;
    localparam int N = 10, W = 12, LW = 4, MINM = 2;

    logic            clock = 1'b0, reset_n = 1'b0, finish = 1'b0, label_ready = 1'b0;
    logic [N*W-1:0]  OutputData = '0;
    logic            label_valid, no_vote, low_conf;
    logic [LW-1:0]   label;
    logic [W-1:0]    label_votes, margin;
    logic [W-1:0]    v [N];
    int              n_chk = 0, n_fail = 0;

    rbm_vote_decoder dut (
        .clock(clock), .reset_n(reset_n), .finish(finish), .OutputData(OutputData),
        .label_valid(label_valid), .label_ready(label_ready), .label(label),
        .label_votes(label_votes), .no_vote(no_vote), .margin(margin), .low_conf(low_conf)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Winner = largest count, lowest index on ties; second = largest of the remaining counts.
    task automatic model(output int bi, output int bv, output int sv);
        bi = 0;
        for (int i = 1; i < N; i++) if (v[i] > v[bi]) bi = i;
        bv = v[bi];
        sv = 0;
        for (int i = 0; i < N; i++) if (i != bi && v[i] > sv) sv = v[i];
    endtask

    task automatic run(input string tag, input bit drop, input int rdelay);
        int bi, bv, sv, cnt, em;
        bit stable, redo;
        model(bi, bv, sv);
        em = bv - sv;
        for (int i = 0; i < N; i++) OutputData[i*W +: W] = v[i];
        finish = 1'b1;
        cnt = 0;
        @(posedge clock); #1;
        while (!label_valid && cnt < 40) begin
            @(posedge clock); #1;
            cnt++;
            if (drop && cnt == 3) finish = 1'b0;
        end
        check({tag, "_latency"}, cnt, N + 1);
        check({tag, "_label"}, label, bi);
        check({tag, "_votes"}, label_votes, bv);
        check({tag, "_no_vote"}, no_vote, bv == 0);
`ifdef MARGIN_CHECK_EN
        check({tag, "_margin"}, margin, em);
        check({tag, "_low_conf"}, low_conf, em < MINM);
`else
        check({tag, "_margin"}, margin, 0);
        check({tag, "_low_conf"}, low_conf, 0);
`endif
        stable = 1'b1;
        repeat (rdelay) begin
            @(posedge clock); #1;
            if (!label_valid || label !== LW'(bi) || label_votes !== W'(bv)) stable = 1'b0;
        end
        check({tag, "_hold"}, stable, 1);
        label_ready = 1'b1;
        @(posedge clock); #1;
        label_ready = 1'b0;
        check({tag, "_accept"}, label_valid, 0);
        check({tag, "_keep"}, label, bi);
        if (finish) begin
            redo = 1'b0;
            repeat (15) begin
                @(posedge clock); #1;
                if (label_valid) redo = 1'b1;
            end
            check({tag, "_no_redecode"}, redo, 0);
            finish = 1'b0;
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #3;
        check("reset_outputs", {label_valid, label, label_votes, no_vote, margin, low_conf}, 0);
        #9 reset_n = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < N; i++) v[i] = 1;
        v[3] = 20;
        run("t1_c3", 1'b0, 5);

        for (int i = 0; i < N; i++) v[i] = 0;
        v[2] = 15; v[7] = 15;
        run("t2_tie", 1'b0, 1);

        for (int i = 0; i < N; i++) v[i] = 0;
        run("t3_zero", 1'b1, 2);

        for (int i = 0; i < N; i++) v[i] = 0;
        v[9] = 4095; v[0] = 4094;
        run("t6_max", 1'b0, 0);

        for (int i = 0; i < N; i++) v[i] = W'(i * 3);
        for (int i = 0; i < N; i++) OutputData[i*W +: W] = v[i];
        finish = 1'b1;
        @(posedge clock); #1;
        repeat (4) @(posedge clock);
        #2 reset_n = 1'b0;
        #1 check("t5_async_reset", {label_valid, label, label_votes, no_vote, margin, low_conf}, 0);
        for (int i = 0; i < N; i++) v[i] = W'(100 - i);
        v[6] = 200;
        #1 reset_n = 1'b1;
        run("t5_after_reset", 1'b0, 1);

        for (int t = 0; t < 24; t++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int i = 0; i < N; i++)
                v[i] = (mode == 0) ? W'($urandom_range(0, 4095)) :
                       (mode == 1) ? W'($urandom_range(0, 3)) : W'($urandom_range(4090, 4095));
            run($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), $urandom_range(0, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
